// File: rtl/lc3b_types.sv
// Shared LC-3b types.
//   lc3b_word      : 16-bit machine word.
//   lc3b_if_state  : fetch-stage control states (FETCH, HOLD, SQUASH).
//   lc3b_pc_sel    : PC next-value source selected by the fetch control.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    SQUASH = 2'd2
  } lc3b_if_state;

  typedef enum logic [1:0] {
    PC_KEEP  = 2'd0,
    PC_INC   = 2'd1,
    PC_REDIR = 2'd2,
    PC_TGT   = 2'd3
  } lc3b_pc_sel;

  // Instruction addresses are word aligned; bit 0 is always cleared.
  function automatic lc3b_word word_align(lc3b_word a);
    return a & 16'hFFFE;
  endfunction

endpackage

// File: rtl/if_control.sv
// Fetch-stage control FSM.
// Ports:
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   imem_resp_i         : instruction memory response this cycle
//   stall_i             : decode stage cannot accept this cycle
//   redirect_i          : control-flow redirect from a later stage
//   de_load_o           : decode register load strobe (combinational)
//   imem_read_o         : memory read request (combinational)
//   pc_sel_o            : PC next-value source
//   hold_ld_o           : capture fetched word into the hold register
//   tgt_ld_o            : capture redirect target while a read is in flight
//   state_o             : current FSM state (debug visibility)
//
// Handshake: a memory read is requested while imem_read_o=1 with a stable
// address; the request completes in the cycle imem_resp_i=1. An instruction
// transfers to decode in any cycle where de_load_o=1; this happens only when
// stall_i=0, so no separate ready signal is needed.
module if_control
  import lc3b_types::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         imem_resp_i,
  input  logic         stall_i,
  input  logic         redirect_i,
  output logic         de_load_o,
  output logic         imem_read_o,
  output lc3b_pc_sel   pc_sel_o,
  output logic         hold_ld_o,
  output logic         tgt_ld_o,
  output lc3b_if_state state_o
);

  lc3b_if_state state_q, state_d;
  logic         de_load_raw;
  logic         read_raw;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    de_load_raw = 1'b0;
    read_raw    = 1'b0;
    pc_sel_o    = PC_KEEP;
    hold_ld_o   = 1'b0;
    tgt_ld_o    = 1'b0;
    case (state_q)
      FETCH: begin
        read_raw = 1'b1;
        if (redirect_i) begin
          if (imem_resp_i) begin
            // Read already done: jump straight to the target.
            pc_sel_o = PC_REDIR;
          end else begin
            // Read still in flight: keep address stable, remember target.
            tgt_ld_o = 1'b1;
            state_d  = SQUASH;
          end
        end else if (imem_resp_i) begin
          if (!stall_i) begin
            de_load_raw = 1'b1;
            pc_sel_o    = PC_INC;
          end else begin
            hold_ld_o = 1'b1;
            state_d   = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect_i) begin
          pc_sel_o = PC_REDIR;
          state_d  = FETCH;
        end else if (!stall_i) begin
          de_load_raw = 1'b1;
          pc_sel_o    = PC_INC;
          state_d     = FETCH;
        end
      end
      SQUASH: begin
        read_raw = 1'b1;
        if (redirect_i) tgt_ld_o = 1'b1;
        if (imem_resp_i) begin
          // A same-cycle redirect is newer than the stored target.
          pc_sel_o = redirect_i ? PC_REDIR : PC_TGT;
          state_d  = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // Memory and decode must see nothing while reset is held.
  assign de_load_o   = de_load_raw & ~rst_i;
  assign imem_read_o = read_raw & ~rst_i;
  assign state_o     = state_q;

endmodule

// File: rtl/if_stage.sv
// LC-3b instruction-fetch stage: owns the PC, issues instruction reads and
// hands each fetched word plus its PC+2 to the decode pipeline register.
// Ports:
//   clk, reset               : clock, asynchronous active-high reset
//   imem_address, imem_read  : fetch request (address stable until resp)
//   imem_resp, imem_rdata    : memory response and instruction word
//   stall                    : decode cannot accept this cycle
//   redirect, redirect_pc    : control-flow redirect and its target
//   if_instr, if_plus2       : instruction and its PC+2 for decode
//   de_load                  : decode register load strobe
module if_stage
  import lc3b_types::*;
#(
  parameter lc3b_word RESET_PC = 16'h0000
) (
  input  logic     clk,
  input  logic     reset,
  output lc3b_word imem_address,
  output logic     imem_read,
  input  logic     imem_resp,
  input  lc3b_word imem_rdata,
  input  logic     stall,
  input  logic     redirect,
  input  lc3b_word redirect_pc,
  output lc3b_word if_instr,
  output lc3b_word if_plus2,
  output logic     de_load
);

  lc3b_word     pc_q, pc_d;
  lc3b_word     hold_q, hold_d;
  lc3b_word     tgt_q, tgt_d;
  lc3b_word     target;
  lc3b_word     pc_plus2;
  lc3b_pc_sel   pc_sel;
  logic         hold_ld;
  logic         tgt_ld;
  lc3b_if_state ctl_state;

  if_control u_ctl (
    .clk_i       (clk),
    .rst_i       (reset),
    .imem_resp_i (imem_resp),
    .stall_i     (stall),
    .redirect_i  (redirect),
    .de_load_o   (de_load),
    .imem_read_o (imem_read),
    .pc_sel_o    (pc_sel),
    .hold_ld_o   (hold_ld),
    .tgt_ld_o    (tgt_ld),
    .state_o     (ctl_state)
  );

  assign target   = word_align(redirect_pc);
  assign pc_plus2 = pc_q + 16'd2;  // wraps FFFE -> 0000

  always_comb begin
    pc_d   = pc_q;
    hold_d = hold_q;
    tgt_d  = tgt_q;
    case (pc_sel)
      PC_INC:   pc_d = pc_plus2;
      PC_REDIR: pc_d = target;
      PC_TGT:   pc_d = tgt_q;
      default:  pc_d = pc_q;
    endcase
    if (hold_ld) hold_d = imem_rdata;
    if (tgt_ld)  tgt_d  = target;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      hold_q <= '0;
      tgt_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      hold_q <= hold_d;
      tgt_q  <= tgt_d;
    end
  end

  assign imem_address = pc_q;
  assign if_plus2     = pc_plus2;
  // In HOLD the word comes from the local capture; otherwise straight from memory.
  assign if_instr     = reset              ? '0 :
                        (ctl_state == HOLD) ? hold_q : imem_rdata;

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the pipelined LC-3b datapath. Owns the PC, issues word reads to instruction memory, and presents each fetched instruction with its PC+2 to the decode pipeline register, which receives `if_instr`/`if_plus2` and loads on `de_load`. Absorbs variable memory latency, downstream stalls and control-flow redirects without dropping or duplicating instructions.

## Interface
Parameters:
- `RESET_PC`, 16'h0000, PC value after reset.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `imem_address`  out  16  fetch address (`lc3b_word`).
- `imem_read`  out  1  read request; held with a stable address until `imem_resp`.
- `imem_resp`  in  1  memory response; `imem_rdata` valid this cycle.
- `imem_rdata`  in  16  instruction word.
- `stall`  in  1  decode stage cannot accept this cycle.
- `redirect`  in  1  taken branch, jump or trap from a later stage.
- `redirect_pc`  in  16  redirect target; bit 0 ignored (forced 0).
- `if_instr`  out  16  instruction to decode register.
- `if_plus2`  out  16  PC+2 of `if_instr`.
- `de_load`  out  1  load strobe for decode register; 1 = valid instruction transferred.

## Operation
- Registers: `pc`, `hold_instr`, `tgt` (pending redirect target), 2-bit state. FSM states: FETCH, HOLD, SQUASH.
- Reset (async): `pc`=RESET_PC, `hold_instr`=0, `tgt`=0, state=FETCH. While `reset`=1: `imem_read`=0, `de_load`=0, `if_instr`=0, `if_plus2`=RESET_PC+2.
- `if_plus2` = `pc`+2 always, modulo 2^16 (16'hFFFE -> 16'h0000).
- `imem_address` = `pc` in all states.
- FETCH: `imem_read`=1; `if_instr`=`imem_rdata`.
  - `redirect`=1: `pc`<=`redirect_pc`&~1. If `imem_resp`=1, stay FETCH; else `tgt`<=target, go SQUASH. `de_load`=0.
  - `imem_resp`=1, `stall`=0: `de_load`=1, `pc`<=`pc`+2, stay FETCH.
  - `imem_resp`=1, `stall`=1: `hold_instr`<=`imem_rdata`, go HOLD, `de_load`=0.
  - `imem_resp`=0: hold everything.
- HOLD: `imem_read`=0; `if_instr`=`hold_instr`.
  - `redirect`=1 (priority over stall release): discard, `pc`<=target, FETCH, `de_load`=0.
  - `stall`=0: `de_load`=1, `pc`<=`pc`+2, FETCH.
  - `stall`=1: remain.
- SQUASH: outstanding read must finish at its original address; `imem_read`=1, address still old `pc`, `de_load`=0.
  - Further `redirect`: `tgt` overwritten (latest wins).
  - `imem_resp`=1: data discarded, `pc`<=`tgt` (or `redirect_pc` if redirect same cycle), FETCH.
- Exactly one `de_load` per fetched, non-squashed instruction, in program order.

## Timing
- Zero-wait memory (`imem_resp` in first request cycle): one instruction per cycle, `de_load` continuous.
- N-cycle memory: `de_load` in the cycle `imem_resp` rises (if no stall); new request address the next cycle.
- Stall during response: instruction delivered in the first cycle `stall`=0, no new memory read issued until then.
- Redirect -> first request to target: next cycle (FETCH/HOLD), or cycle after squashed response (SQUASH).
- Reset deassertion mid-transaction: memory sees `imem_read` drop; fetch restarts at RESET_PC.
- `de_load`, `if_instr`, `imem_read` are combinational from state and inputs; no input-to-state combinational loops.

## Structure
- `lc3b_word` from `lc3b_types`; add `lc3b_if_state` enum (FETCH, HOLD, SQUASH) to that package.
- `pc`, `hold_instr`, `tgt` built from existing `register` module (width 16) with added async reset, or local flops.
- Sub-module: `if_control` (FSM: next-state, `de_load`, `imem_read`, register load enables); datapath muxes and +2 adder in `if_stage`.

## Test plan
- Reset, zero-wait memory, stall=0 -> addresses 0000,0002,0004; `de_load` every cycle; `if_plus2` 0002,0004,0006.
- 3-cycle memory, `stall`=1 on resp of 0x1234 at pc 0x0010 for 2 cycles -> HOLD, `imem_read`=0, `if_instr`=0x1234 held; `de_load` once on release; next fetch 0x0012.
- Redirect to 0x0101 two cycles into a 3-cycle read at 0x0020 -> address stays 0x0020 until resp, data not loaded, next fetch 0x0100.
- Redirect in SQUASH twice (0x0200 then 0x0300) -> next fetch 0x0300 only.
- pc=0xFFFE, resp, stall=0 -> `if_plus2`=0x0000, next fetch 0x0000.
- Reset asserted during outstanding read -> `imem_read`=0 immediately; after release fetch at RESET_PC, no `de_load` for the aborted read.
